// File: rtl/charge_pkg.sv
// Shared definitions for the charge_station keypad front end and channels:
// key-code constants, front-end FSM state encoding, and the saturating
// decimal accumulate used for payment entry.
package charge_pkg;

  localparam logic [4:0] KEY_ZERO_ALT = 5'd10;
  localparam logic [4:0] KEY_START    = 5'd11;
  localparam logic [4:0] KEY_CLEAR    = 5'd12;
  localparam logic [4:0] KEY_ENTER    = 5'd13;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ENTRY = 2'd1;
  localparam state_t ST_LOAD  = 2'd2;

  // Appends one decimal digit at full width, then clamps to the limit.
  function automatic int unsigned sat_accum(input int unsigned cur,
                                            input int unsigned digit,
                                            input int unsigned limit);
    int unsigned nxt;
    nxt = cur * 10 + digit;
    return (nxt > limit) ? limit : nxt;
  endfunction

endpackage

// File: rtl/charge_channel.sv
// One charging channel: remaining-time countdown with load, abort and a
// shared tick. busy is high while time remains; done pulses for one cycle on
// the 1->0 step. Load has priority over abort, abort over the tick.
import charge_pkg::*;

module charge_channel #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          abort,
  input  logic          tick,
  output logic [TW-1:0] remaining,
  output logic          busy,
  output logic          done
);

  // Countdown register with load/abort/tick priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        remaining <= load_val;
        busy      <= (load_val != '0);
      end else if (abort) begin
        remaining <= '0;
        busy      <= 1'b0;
      end else if (tick && busy) begin
        remaining <= remaining - 1'b1;
        if (remaining == TW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/charge_station.sv
// Multi-channel charge station: keypad press detect, payment-entry FSM,
// shared tick divider, N_CH countdown channels and the restime display mux.
// Optional: define CHARGE_STATION_ENTRY_TIMEOUT_EN to abandon an entry after
// TIMEOUT idle cycles (returns to IDLE, money cleared, key_err pulsed).
import charge_pkg::*;

module charge_station #(
  parameter  int unsigned N_CH      = 4,
  parameter  int unsigned MAX_MONEY = 20,
  parameter  int unsigned RATE      = 2,
  parameter  int unsigned MW        = 8,
  parameter  int unsigned TW        = 8,
  parameter  int unsigned TICK_DIV  = 4,
  parameter  int unsigned TIMEOUT   = 64,
  localparam int unsigned CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            key_set,
  input  logic [4:0]      key_code,
  input  logic [CW-1:0]   ch_sel,
  input  logic [CW-1:0]   disp_ch,
  output logic [MW-1:0]   money,
  output logic [TW-1:0]   restime,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] done,
  output logic            key_err
);

  if (64'(MAX_MONEY) * 64'(RATE) >= (64'd1 << TW)) begin : g_chk_tw
    $error("charge_station: MAX_MONEY*RATE does not fit in TW bits");
  end
  if (TICK_DIV < 1 || TIMEOUT < 1 || N_CH < 1 || N_CH > 8) begin : g_chk_par
    $error("charge_station: TICK_DIV, TIMEOUT must be >= 1 and N_CH in 1..8");
  end

  state_t          state;
  logic            key_prev;
  logic            press;
  logic [3:0]      digit_val;
  logic            is_digit;
  logic [CW-1:0]   lat_ch;
  logic [31:0]     tick_cnt;
  logic            tick;
  logic [N_CH-1:0] load_vec;
  logic [N_CH-1:0] abort_vec;
  logic [TW-1:0]   load_val;
  logic [TW-1:0]   rem [N_CH];
`ifdef CHARGE_STATION_ENTRY_TIMEOUT_EN
  logic [31:0]     idle_cnt;
`endif

  assign press     = key_set & ~key_prev;
  assign is_digit  = (key_code <= KEY_ZERO_ALT);
  assign digit_val = (key_code == KEY_ZERO_ALT) ? 4'd0 : key_code[3:0];
  assign tick      = (tick_cnt == TICK_DIV - 1);
  assign load_val  = TW'(32'(money) * RATE);

  // Free-running tick divider shared by all channels.
  always_ff @(posedge CLK) begin
    if (RST || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  // Per-channel load (LOAD state) and abort (CLEAR in IDLE) strobes.
  always_comb begin
    load_vec  = '0;
    abort_vec = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      load_vec[i]  = (state == ST_LOAD) && (lat_ch == CW'(i));
      abort_vec[i] = (state == ST_IDLE) && press && (key_code == KEY_CLEAR)
                     && (ch_sel == CW'(i));
    end
  end

  // Front-end FSM: press detection, channel latch and payment entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      money    <= '0;
      lat_ch   <= '0;
      key_prev <= 1'b0;
      key_err  <= 1'b0;
`ifdef CHARGE_STATION_ENTRY_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      key_prev <= key_set;
      key_err  <= 1'b0;
`ifdef CHARGE_STATION_ENTRY_TIMEOUT_EN
      idle_cnt <= (state == ST_ENTRY && !press) ? idle_cnt + 1'b1 : '0;
`endif
      case (state)
        ST_IDLE: begin
          if (press && key_code == KEY_START) begin
            if (busy[ch_sel]) begin
              key_err <= 1'b1;
            end else begin
              lat_ch <= ch_sel;
              money  <= '0;
              state  <= ST_ENTRY;
            end
          end
        end
        ST_ENTRY: begin
          if (press) begin
            if (is_digit) begin
              money <= MW'(sat_accum(32'(money), 32'(digit_val), MAX_MONEY));
            end else if (key_code == KEY_START) begin
              if (busy[ch_sel]) begin
                key_err <= 1'b1;
              end else begin
                lat_ch <= ch_sel;
                money  <= '0;
              end
            end else if (key_code == KEY_ENTER) begin
              state <= (money != '0) ? ST_LOAD : ST_IDLE;
            end else if (key_code == KEY_CLEAR) begin
              money <= '0;
              state <= ST_IDLE;
            end
          end
`ifdef CHARGE_STATION_ENTRY_TIMEOUT_EN
          else if (idle_cnt >= TIMEOUT - 1) begin
            money   <= '0;
            key_err <= 1'b1;
            state   <= ST_IDLE;
          end
`endif
        end
        ST_LOAD: begin
          money <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Display mux, registered from the channel array.
  always_ff @(posedge CLK) begin
    if (RST) restime <= '0;
    else     restime <= rem[disp_ch];
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    charge_channel #(.TW(TW)) u_ch (
      .clk      (CLK),
      .rst      (RST),
      .load     (load_vec[g]),
      .load_val (load_val),
      .abort    (abort_vec[g]),
      .tick     (tick),
      .remaining(rem[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

endmodule

// File: tb/tb_charge_station.sv
// Directed self-checking bench for charge_station (default parameters).
module tb_charge_station;

  localparam logic [4:0] K_START = 5'd11;
  localparam logic [4:0] K_CLEAR = 5'd12;
  localparam logic [4:0] K_ENTER = 5'd13;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_set;
  logic [4:0] key_code;
  logic [1:0] ch_sel;
  logic [1:0] disp_ch;
  logic [7:0] money;
  logic [7:0] restime;
  logic [3:0] busy;
  logic [3:0] done;
  logic       key_err;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt [4];
  int err_cnt = 0;

  always #5 clk = ~clk;

  charge_station dut (
    .CLK     (clk),
    .RST     (rst),
    .key_set (key_set),
    .key_code(key_code),
    .ch_sel  (ch_sel),
    .disp_ch (disp_ch),
    .money   (money),
    .restime (restime),
    .busy    (busy),
    .done    (done),
    .key_err (key_err)
  );

  initial for (int i = 0; i < 4; i++) done_cnt[i] = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (done[i] === 1'b1) done_cnt[i]++;
    if (key_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge two edges after the press.
  task automatic press(input logic [4:0] code, input int hold);
    key_code = code;
    key_set  = 1'b1;
    repeat (hold) @(negedge clk);
    key_set = 1'b0;
    @(negedge clk);
  endtask

  int d0, e0, r0;
  int dc [4];

  initial begin
    rst = 1'b1; key_set = 1'b0; key_code = '0; ch_sel = '0; disp_ch = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_money", money, 0);
    check("rst_restime", restime, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_key_err", key_err, 0);

    // Basic charge on ch0: 15 -> 30 time units.
    ch_sel = 2'd0; disp_ch = 2'd0;
    press(K_START, 1);
    press(5'd1, 1);  check("basic_m1", money, 1);
    press(5'd5, 1);  check("basic_m15", money, 15);
    d0 = done_cnt[0];
    press(K_ENTER, 1);
    check("basic_busy", busy, 4'b0001);
    check("basic_money_clr", money, 0);
    @(negedge clk);
    check("basic_restime", restime, 30);
    for (int i = 0; i < 200 && done_cnt[0] == d0; i++) @(negedge clk);
    check("basic_done", done_cnt[0], d0 + 1);
    repeat (3) @(negedge clk);
    check("basic_done_once", done_cnt[0], d0 + 1);
    check("basic_busy_off", busy, 0);
    check("basic_restime0", restime, 0);

    // Saturation: 4, 43->20, 206->20, restime 40.
    press(K_START, 1);
    press(5'd4, 1);  check("sat_4", money, 4);
    press(5'd3, 1);  check("sat_20a", money, 20);
    press(5'd6, 1);  check("sat_20b", money, 20);
    press(K_ENTER, 1);
    @(negedge clk);
    check("sat_restime", restime, 40);

    // Busy reject on ch0, then ch1 with 2 -> 4.
    e0 = err_cnt;
    press(K_START, 1);
    check("rej_err", err_cnt, e0 + 1);
    check("rej_busy", busy, 4'b0001);
    r0 = restime;
    ch_sel = 2'd1;
    press(K_START, 1);
    press(5'd2, 1);  check("ch1_m2", money, 2);
    press(K_ENTER, 1);
    check("ch1_busy", busy, 4'b0011);
    disp_ch = 2'd1;
    @(negedge clk);
    check("ch1_restime", restime, 4);
    disp_ch = 2'd0;
    @(negedge clk);
    check("ch0_decr", (restime < r0 && restime > 0), 1);
    check("rej_err_total", err_cnt, e0 + 1);

    // Held key on ch2: one accumulate only; CLEAR returns to IDLE.
    ch_sel = 2'd2;
    press(K_START, 1);
    press(5'd3, 5);  check("held_m3", money, 3);
    press(K_CLEAR, 1); check("clr_money", money, 0);
    press(5'd7, 1);  check("clr_idle_digit", money, 0);
    check("clr_no_err", err_cnt, e0 + 1);

    // Abort ch0 from IDLE: no done.
    ch_sel = 2'd0; disp_ch = 2'd0;
    d0 = done_cnt[0];
    press(K_CLEAR, 1);
    check("abort_busy0", busy[0], 0);
    check("abort_restime", restime, 0);
    repeat (200) @(negedge clk);
    check("abort_no_done", done_cnt[0], d0);

    // Two channels charging (9 -> 18 each), then reset mid-charge.
    ch_sel = 2'd2;
    press(K_START, 1); press(5'd9, 1); press(K_ENTER, 1);
    ch_sel = 2'd3;
    press(K_START, 1); press(5'd9, 1); press(K_ENTER, 1);
    check("two_busy", busy, 4'b1100);
    disp_ch = 2'd2;
    for (int i = 0; i < 4; i++) dc[i] = done_cnt[i];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_restime", restime, 0);
    check("rstmid_money", money, 0);
    repeat (100) @(negedge clk);
    check("rstmid_no_done2", done_cnt[2], dc[2]);
    check("rstmid_no_done3", done_cnt[3], dc[3]);

    // Zero ENTER returns to IDLE without charging.
    e0 = err_cnt;
    ch_sel = 2'd0;
    press(K_START, 1);
    press(K_ENTER, 1);
    @(negedge clk);
    check("zero_busy", busy, 0);
    press(5'd5, 1);  check("zero_idle_digit", money, 0);

    // Ignored code and alternate zero key during entry.
    press(K_START, 1);
    press(5'd20, 1); check("ign_money", money, 0);
    press(5'd1, 1);  check("alt0_m1", money, 1);
    press(5'd10, 1); check("alt0_m10", money, 10);
    check("ign_no_err", err_cnt, e0);
    press(K_CLEAR, 1); check("final_clr", money, 0);
    check("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
